// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - memory, redirect and decode-side signals of the fetch sequencer
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [31:0]       imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              branch_taken;
  logic [31:0]       branch_addr;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [31:0]       out_pc;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  branch_taken,
    input  branch_addr,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output branch_taken,
    output branch_addr,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO; flush wins over push and pop, storage is
// reset so the head never reads X even while empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Push into a full queue only happens alongside a pop, so the slot
      // being overwritten is the head that leaves on this same edge.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - owns the fetch PC and run state, qualifies pushes
// from instruction memory and pops toward decode, and redirects on branches.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  fetch_sequencer_if.master   bus,
  output logic                ended
);

  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_END  = ST_END;

  logic [31:0]  r_pc;
  logic [1:0]   r_state;

  logic         w_pc_in_range;
  logic [31:0]  w_target;
  logic         w_target_in_range;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_wr_data;
  fetch_entry_t w_head;

  // Widened compare so a wrapped PC can never look in range.
  assign w_pc_in_range     = ({1'b0, r_pc} < PC_LIMIT);
  assign w_target          = {bus.branch_addr[31:2], 2'b00};
  assign w_target_in_range = ({1'b0, w_target} < PC_LIMIT);

  assign w_pop  = !w_empty && bus.out_ready && !bus.branch_taken;
  assign w_push = (r_state == S_RUN) && fetch_en && w_pc_in_range &&
                  !bus.branch_taken && (!w_full || w_pop);

  always_comb begin
    w_wr_data          = '0;
    w_wr_data.inst     = bus.imem_inst;
    w_wr_data.pc_plus4 = r_pc + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (bus.branch_taken) begin
      r_pc <= w_target;
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (bus.branch_taken) begin
      // A redirect never wakes an idle fetcher; it only restarts one that ran off the end.
      if (r_state == S_END && w_target_in_range) begin
        r_state <= S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE: if (fetch_en) r_state <= S_RUN;
        S_RUN: begin
          if (!fetch_en) begin
            r_state <= S_IDLE;
          end else if (!w_pc_in_range) begin
            r_state <= S_END;
          end
        end
        S_END:   r_state <= S_END;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.branch_taken),
    .i_data  (w_wr_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = !w_empty;
  assign bus.out_inst  = w_head.inst;
  assign bus.out_pc    = w_head.pc_plus4;
  assign ended         = (r_state == S_END);

endmodule
